// File: rtl/microsequencer_next_state.sv
// ---------------------------------------------------------------------------
// microsequencer_next_state : registered next-microaddress generator with a
// return-address stack for micro-subroutines.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module microsequencer_next_state #(
  parameter int ADDR_W      = 10,
  parameter int STACK_DEPTH = 4,
  parameter int RESET_STATE = 0
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [ADDR_W-1:0]              current_state,
  input  logic [ADDR_W-1:0]              cr_addr,
  input  logic [ADDR_W-1:0]              encoder_addr,
  input  logic [2:0]                     ns_sel,
  input  logic [2:0]                     cond_sel,
  input  logic                           inv,
  input  logic                           flag_z,
  input  logic                           flag_c,
  input  logic                           flag_n,
  input  logic                           flag_v,
  input  logic                           moc,
  input  logic                           cond_ext,
  input  logic                           stall,
  output logic [ADDR_W-1:0]              next_state,
  output logic [$clog2(STACK_DEPTH):0]   sp,
  output logic                           stk_ovf,
  output logic                           stk_unf
);

  localparam int SP_W = $clog2(STACK_DEPTH) + 1;
  localparam int IDX_W = SP_W - 1;
  localparam logic [ADDR_W-1:0] RST_ADDR = ADDR_W'(RESET_STATE);

  localparam logic [2:0] NS_DECODE = 3'd0;
  localparam logic [2:0] NS_JUMP   = 3'd1;
  localparam logic [2:0] NS_INC    = 3'd2;
  localparam logic [2:0] NS_BRANCH = 3'd3;
  localparam logic [2:0] NS_WAIT   = 3'd4;
  localparam logic [2:0] NS_CALL   = 3'd5;
  localparam logic [2:0] NS_RET    = 3'd6;
  localparam logic [2:0] NS_HALT   = 3'd7;

  logic [ADDR_W-1:0] stack_mem [STACK_DEPTH];

  logic              w_cond_raw;
  logic              w_cond;
  logic [ADDR_W-1:0] w_inc;
  logic [ADDR_W-1:0] w_ns;
  logic [SP_W-1:0]   w_sp_m1;
  logic [IDX_W-1:0]  w_wr_idx;
  logic [IDX_W-1:0]  w_rd_idx;
  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;
  logic              w_ovf_set;
  logic              w_unf_set;

  assign w_inc    = current_state + ADDR_W'(1);
  assign w_sp_m1  = sp - SP_W'(1);
  assign w_wr_idx = sp[IDX_W-1:0];
  assign w_rd_idx = w_sp_m1[IDX_W-1:0];
  assign w_full   = (sp == SP_W'(STACK_DEPTH));
  assign w_empty  = (sp == '0);

  always_comb begin
    w_cond_raw = 1'b0;
    case (cond_sel)
      3'd0:    w_cond_raw = flag_z;
      3'd1:    w_cond_raw = flag_c;
      3'd2:    w_cond_raw = flag_n;
      3'd3:    w_cond_raw = flag_v;
      3'd4:    w_cond_raw = moc;
      3'd5:    w_cond_raw = 1'b1;
      3'd6:    w_cond_raw = cond_ext;
      default: w_cond_raw = 1'b0;
    endcase
    w_cond = w_cond_raw ^ inv;
  end

  always_comb begin
    w_ns      = next_state;
    w_push    = 1'b0;
    w_pop     = 1'b0;
    w_ovf_set = 1'b0;
    w_unf_set = 1'b0;
    case (ns_sel)
      NS_DECODE: w_ns = encoder_addr;
      NS_JUMP:   w_ns = cr_addr;
      NS_INC:    w_ns = w_inc;
      NS_BRANCH: w_ns = w_cond ? cr_addr : w_inc;
      NS_WAIT:   w_ns = w_cond ? w_inc : current_state;
      NS_CALL: begin
        // A call on a full stack still jumps; only the push is dropped.
        w_ns = cr_addr;
        if (w_full) w_ovf_set = 1'b1;
        else        w_push    = 1'b1;
      end
      NS_RET: begin
        if (w_empty) begin
          w_ns      = RST_ADDR;
          w_unf_set = 1'b1;
        end else begin
          w_ns  = stack_mem[w_rd_idx];
          w_pop = 1'b1;
        end
      end
      NS_HALT:   w_ns = RST_ADDR;
      default:   w_ns = next_state;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      next_state <= RST_ADDR;
      sp         <= '0;
      stk_ovf    <= 1'b0;
      stk_unf    <= 1'b0;
    end else if (!stall) begin
      next_state <= w_ns;
      if (w_push)     sp <= sp + SP_W'(1);
      else if (w_pop) sp <= w_sp_m1;
      stk_ovf <= stk_ovf | w_ovf_set;
      stk_unf <= stk_unf | w_unf_set;
    end
  end

  // Stack contents need no reset; occupancy alone defines validity.
  always_ff @(posedge clk) begin
    if (!reset && !stall && w_push)
      stack_mem[w_wr_idx] <= w_inc;
  end

endmodule

`default_nettype wire

// File: tb/tb_microsequencer_next_state.sv
// ---------------------------------------------------------------------------
// tb_microsequencer_next_state : directed vector table plus randomized run
// against a queue-based reference model.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_microsequencer_next_state;

  localparam int ADDR_W = 10;
  localparam int DEPTH  = 4;
  localparam int MASK   = (1 << ADDR_W) - 1;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [ADDR_W-1:0] current_state = '0;
  logic [ADDR_W-1:0] cr_addr = '0;
  logic [ADDR_W-1:0] encoder_addr = '0;
  logic [2:0]        ns_sel = '0;
  logic [2:0]        cond_sel = '0;
  logic              inv = 1'b0;
  logic              flag_z = 1'b0, flag_c = 1'b0, flag_n = 1'b0, flag_v = 1'b0;
  logic              moc = 1'b0;
  logic              cond_ext = 1'b0;
  logic              stall = 1'b0;
  logic [ADDR_W-1:0] next_state;
  logic [2:0]        sp;
  logic              stk_ovf;
  logic              stk_unf;

  int errors = 0;
  int checks = 0;

  microsequencer_next_state #(.ADDR_W(ADDR_W), .STACK_DEPTH(DEPTH), .RESET_STATE(0)) dut (
    .clk(clk), .reset(reset), .current_state(current_state), .cr_addr(cr_addr),
    .encoder_addr(encoder_addr), .ns_sel(ns_sel), .cond_sel(cond_sel), .inv(inv),
    .flag_z(flag_z), .flag_c(flag_c), .flag_n(flag_n), .flag_v(flag_v), .moc(moc),
    .cond_ext(cond_ext), .stall(stall), .next_state(next_state), .sp(sp),
    .stk_ovf(stk_ovf), .stk_unf(stk_unf)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit       rst;
    bit       stl;
    int       ns;
    int       cs;
    bit       iv;
    bit [3:0] zcnv;
    bit       mc;
    int       cur;
    int       cr;
    int       enc;
    int       exp_ns;
    int       exp_sp;
    bit       exp_ovf;
    bit       exp_unf;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input bit r, input bit s, input int n, input int c, input bit i,
                     input bit [3:0] f, input bit m, input int cu, input int crv, input int en,
                     input int ens, input int esp, input bit eo, input bit eu);
    vec_t v;
    v.rst = r; v.stl = s; v.ns = n; v.cs = c; v.iv = i; v.zcnv = f; v.mc = m;
    v.cur = cu; v.cr = crv; v.enc = en;
    v.exp_ns = ens; v.exp_sp = esp; v.exp_ovf = eo; v.exp_unf = eu;
    vecs.push_back(v);
  endtask

  // Reference model state: plain queue for the return stack.
  int mdl_ns;
  int mdl_stk[$];
  bit mdl_ovf, mdl_unf;

  function automatic void model_step();
    bit conds[8];
    bit c;
    int inc;
    conds = '{flag_z, flag_c, flag_n, flag_v, moc, 1'b1, cond_ext, 1'b0};
    c   = conds[cond_sel] ^ inv;
    inc = (int'(current_state) + 1) % (1 << ADDR_W);
    if (reset) begin
      mdl_ns = 0; mdl_stk.delete(); mdl_ovf = 0; mdl_unf = 0;
    end else if (!stall) begin
      case (ns_sel)
        3'd0: mdl_ns = encoder_addr;
        3'd1: mdl_ns = cr_addr;
        3'd2: mdl_ns = inc;
        3'd3: mdl_ns = c ? int'(cr_addr) : inc;
        3'd4: mdl_ns = c ? inc : int'(current_state);
        3'd5: begin
          if (mdl_stk.size() == DEPTH) mdl_ovf = 1;
          else mdl_stk.push_back(inc);
          mdl_ns = cr_addr;
        end
        3'd6: begin
          if (mdl_stk.size() == 0) begin mdl_ns = 0; mdl_unf = 1; end
          else mdl_ns = mdl_stk.pop_back();
        end
        default: mdl_ns = 0;
      endcase
    end
  endfunction

  initial begin
    // reset
    add(1,0,1,0,0,4'b0,0,'h000,'h155,0,     'h000,0,0,0);
    add(1,0,1,0,0,4'b0,0,'h000,'h155,0,     'h000,0,0,0);
    add(0,0,2,0,0,4'b0,0,'h000,0,0,         'h001,0,0,0);
    // decode / increment wrap
    add(0,0,0,0,0,4'b0,0,0,0,'h014,         'h014,0,0,0);
    add(0,0,2,0,0,4'b0,0,'h3FF,0,0,         'h000,0,0,0);
    // branch polarity
    add(0,0,3,0,0,4'b1000,0,'h016,'h028,0,  'h028,0,0,0);
    add(0,0,3,0,1,4'b1000,0,'h016,'h028,0,  'h017,0,0,0);
    add(0,0,3,7,0,4'b1000,0,'h016,'h028,0,  'h017,0,0,0);
    // memory wait
    for (int k = 0; k < 3; k++)
      add(0,0,4,4,0,4'b0,0,'h019,0,0,       'h019,0,0,0);
    add(0,0,4,4,0,4'b0,1,'h019,0,0,         'h01A,0,0,0);
    // call / return nesting
    add(0,0,5,0,0,4'b0,0,'h030,'h0C8,0,     'h0C8,1,0,0);
    add(0,0,5,0,0,4'b0,0,'h0C9,'h0E0,0,     'h0E0,2,0,0);
    add(0,0,6,0,0,4'b0,0,'h0E0,0,0,         'h0CA,1,0,0);
    add(0,0,6,0,0,4'b0,0,'h0CA,0,0,         'h031,0,0,0);
    add(0,0,6,0,0,4'b0,0,'h031,0,0,         'h000,0,0,1);
    add(1,0,0,0,0,4'b0,0,0,0,0,             'h000,0,0,0);
    // overflow, then stall and halt
    for (int k = 0; k < 5; k++)
      add(0,0,5,0,0,4'b0,0,'h100+k,'h200+k,0, 'h200+k, (k < 4) ? k+1 : 4, k == 4, 0);
    add(0,0,6,0,0,4'b0,0,'h204,0,0,         'h104,3,1,0);
    add(0,1,6,0,0,4'b0,0,'h104,0,0,         'h104,3,1,0);
    add(0,0,7,0,0,4'b0,0,'h104,0,0,         'h000,3,1,0);

    foreach (vecs[i]) begin
      reset = vecs[i].rst; stall = vecs[i].stl;
      ns_sel = 3'(vecs[i].ns); cond_sel = 3'(vecs[i].cs); inv = vecs[i].iv;
      {flag_z, flag_c, flag_n, flag_v} = vecs[i].zcnv; moc = vecs[i].mc;
      current_state = ADDR_W'(vecs[i].cur); cr_addr = ADDR_W'(vecs[i].cr);
      encoder_addr = ADDR_W'(vecs[i].enc);
      @(posedge clk); #1;
      check($sformatf("vec%0d next_state", i), int'(next_state), vecs[i].exp_ns);
      check($sformatf("vec%0d sp", i), int'(sp), vecs[i].exp_sp);
      check($sformatf("vec%0d stk_ovf", i), int'(stk_ovf), int'(vecs[i].exp_ovf));
      check($sformatf("vec%0d stk_unf", i), int'(stk_unf), int'(vecs[i].exp_unf));
    end

    // Randomized phase: start from a known reset, then free-run against the model.
    mdl_ns = 0; mdl_stk.delete(); mdl_ovf = 0; mdl_unf = 0;
    for (int n = 0; n < 600; n++) begin
      reset    = (n == 0) || ($urandom_range(99) < 2);
      stall    = ($urandom_range(99) < 10);
      ns_sel   = 3'($urandom_range(99) < 50 ? ($urandom_range(1) ? 5 : 6) : $urandom_range(7));
      cond_sel = 3'($urandom_range(7));
      inv      = 1'($urandom_range(1));
      {flag_z, flag_c, flag_n, flag_v, moc, cond_ext} = 6'($urandom_range(63));
      current_state = ADDR_W'($urandom_range(MASK));
      cr_addr       = ADDR_W'($urandom_range(MASK));
      encoder_addr  = ADDR_W'($urandom_range(MASK));
      model_step();
      @(posedge clk); #1;
      check($sformatf("rnd%0d next_state", n), int'(next_state), mdl_ns);
      check($sformatf("rnd%0d sp", n), int'(sp), mdl_stk.size());
      check($sformatf("rnd%0d stk_ovf", n), int'(stk_ovf), int'(mdl_ovf));
      check($sformatf("rnd%0d stk_unf", n), int'(stk_unf), int'(mdl_unf));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/microsequencer_next_state.md
Name: microsequencer_next_state

Overview:
- Next-state generator for the microprogrammed control unit. It sits directly upstream of the microstore.
- Each clock it registers the address of the next microinstruction. The microstore uses that address combinationally to produce the control word and current_state.
- Sources for the next address: the instruction encoder, the control-word address field, the incrementer (current_state+1), hold, and a return-address stack for micro-subroutines.

Parameters:
- ADDR_W, 10, microstate address width; matches the microstore next_state/current_state width.
- STACK_DEPTH, 4, return-address stack entries (2..8).
- RESET_STATE, 0, address loaded on reset and on HALT.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- current_state  input  ADDR_W  state currently presented by the microstore
- cr_addr  input  ADDR_W  target-address field of the current control word
- encoder_addr  input  ADDR_W  first microstate of the decoded instruction, from the instruction encoder
- ns_sel  input  3  next-address mode from the control word
- cond_sel  input  3  condition select from the control word
- inv  input  1  inverts the selected condition
- flag_z, flag_c, flag_n, flag_v  input  1 each  ALU status flags
- moc  input  1  memory operation complete
- cond_ext  input  1  spare external condition
- stall  input  1  freeze the sequencer
- next_state  output  ADDR_W  registered address driven to the microstore
- sp  output  clog2(STACK_DEPTH)+1  stack occupancy
- stk_ovf  output  1  sticky overflow flag
- stk_unf  output  1  sticky underflow flag

Behaviour:
- Reset: on a clk edge with reset=1, next_state=RESET_STATE, sp=0, stk_ovf=0, stk_unf=0. Reset overrides stall and every mode. Stack contents are don't-care after reset.
- Condition: cond = sel(cond_sel) ^ inv.
  - Select map: 0 flag_z, 1 flag_c, 2 flag_n, 3 flag_v, 4 moc, 5 const 1, 6 cond_ext, 7 const 0.
- Incrementer: inc = current_state + 1, modulo 2^ADDR_W; 1023 wraps to 0.
- Latency: every update is registered. The mode decoded in cycle k determines next_state after edge k. There is no combinational path from any input to next_state.
- stall=1: next_state, sp and the flags all hold. Mode is ignored; a CALL or RET under stall has no effect.
- ns_sel modes, each applied on the clk edge:
  - 0 DECODE: next_state=encoder_addr.
  - 1 JUMP: next_state=cr_addr.
  - 2 INC: next_state=inc.
  - 3 BRANCH: next_state = cond ? cr_addr : inc.
  - 4 WAIT: next_state = cond ? inc : current_state. Used to spin on moc.
  - 5 CALL: push inc, sp+1, next_state=cr_addr.
    - If sp==STACK_DEPTH: no push, sp unchanged, stk_ovf<=1, jump still taken.
  - 6 RET: next_state=top entry, sp-1.
    - If sp==0: next_state=RESET_STATE, sp stays 0, stk_unf<=1.
  - 7 HALT: next_state=RESET_STATE. Stack is unchanged.
- Stack: LIFO, top = entry[sp-1]. Occupancy goes to full (sp=STACK_DEPTH). The overflow and underflow flags clear only on reset.
- Priority: reset > stall > ns_sel. Only one stack operation is possible per cycle.

Test Plan:
- Reset: drive reset=1 for 2 cycles with ns_sel=1, cr_addr=0x155 -> next_state=0, sp=0, both flags 0. Release reset with ns_sel=2, current_state=0 -> next_state=1 after one edge.
- Decode and increment: encoder_addr=0x014, ns_sel=0 -> next_state=0x014. Then current_state=0x3FF, ns_sel=2 -> next_state=0x000 (wrap).
- Branch polarity: cond_sel=0, flag_z=1, inv=0, cr_addr=0x028, current_state=0x016, ns_sel=3 -> 0x028. Set inv=1 -> 0x017. cond_sel=7 with inv=0 -> 0x017.
- Memory wait: ns_sel=4, cond_sel=4, current_state=0x019, moc=0 for 3 cycles -> next_state holds 0x019. Raise moc=1 -> 0x01A on the next edge.
- Call/return nesting: CALL from 0x030 to 0x0C8, then CALL from 0x0C9 to 0x0E0 -> sp=2. RET -> 0x0CA, sp=1. RET -> 0x031, sp=0. RET again -> 0x000, stk_unf=1.
- Overflow and stall: 5 CALLs with STACK_DEPTH=4 -> sp=4, stk_ovf=1, 5th jump taken. Next RET returns the 4th pushed address. With stall=1 and ns_sel=6 -> next_state, sp and flags are unchanged.
